// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int FIFO_DEPTH = 8;

    // Requester id width; a single-bit id is kept even for degenerate counts
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin picker: first requester after rr_ptr, wrapping
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        idx_w  = '0;
        // Start one past the last owner so it has lowest priority this round
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = (int'(rr_ptr) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!any && req[idx_w]) begin
                any    = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin arbiter for a sync FIFO write port
// Optional build macro FIFO_ARB_AF_THROTTLE_EN: no new packet starts while the FIFO is almost full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int TIMEOUT = 16,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_enb,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      fifo_full,
    input  logic                      fifo_almost_full,
    input  logic                      fifo_overrun,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    input  logic                      clear_err,
    output logic                      err_overrun,
    output logic                      err_timeout
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic [CNT_W-1:0] idle_cnt;
    logic             gate_open;
    logic             locked;
    logic             owner_valid;
    logic             owner_last;
    logic             timeout_hit;

`ifdef FIFO_ARB_AF_THROTTLE_EN
    assign gate_open = !fifo_full && !fifo_almost_full;
`else
    logic unused_almost_full;
    assign unused_almost_full = fifo_almost_full;
    assign gate_open          = !fifo_full;
`endif

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    assign locked      = (state == ST_LOCK);
    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];

    // A stalled FIFO is not the owner's fault, so fifo_full freezes the idle count
    assign timeout_hit = (TIMEOUT != 0) && locked && !fifo_full && !owner_valid
                         && (idle_cnt == CNT_LAST);

    always_comb begin
        req_ready = '0;
        if (locked) begin
            req_ready[owner] = !fifo_full;
        end
    end

    assign wr_enb   = locked && owner_valid && !fifo_full;
    assign wr_data  = locked ? req_data[owner*DATA_W +: DATA_W] : '0;
    assign busy     = locked;
    assign grant_id = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            idle_cnt    <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (pick_any && gate_open) begin
                        owner <= pick_id;
                        state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (wr_enb && owner_last) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= owner;
                        idle_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= owner;
                        idle_cnt <= '0;
                    end else if (owner_valid) begin
                        idle_cnt <= '0;
                    end else if (!fifo_full) begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Setting wins over clearing so an event in the clear cycle is not lost
            if (fifo_overrun) begin
                err_overrun <= 1'b1;
            end else if (clear_err) begin
                err_overrun <= 1'b0;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (clear_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with an 8-deep FIFO model
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct {
        int        id;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [3:0] mask;
        int         exp_id;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             wr_enb;
    logic [DW-1:0]    wr_data;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             fifo_overrun;
    logic [1:0]       grant_id;
    logic             busy;
    logic             clear_err;
    logic             err_overrun;
    logic             err_timeout;

    logic             rd_en;
    int               f_cnt;
    logic             f_ovr;

    int  n_chk  = 0;
    int  n_fail = 0;
    sb_t exp_q[$];
    sb_t mon_e;
    vec_t tbl[12];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .wr_enb           (wr_enb),
        .wr_data          (wr_data),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_overrun     (fifo_overrun),
        .grant_id         (grant_id),
        .busy             (busy),
        .clear_err        (clear_err),
        .err_overrun      (err_overrun),
        .err_timeout      (err_timeout)
    );

    // 8-deep FIFO occupancy model; overrun is sticky until reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt <= 0;
            f_ovr <= 1'b0;
        end else begin
            if (wr_enb && f_cnt == 8) f_ovr <= 1'b1;
            f_cnt <= f_cnt + ((wr_enb && f_cnt != 8) ? 1 : 0) - ((rd_en && f_cnt != 0) ? 1 : 0);
        end
    end
    assign fifo_full        = (f_cnt == 8);
    assign fifo_almost_full = (f_cnt >= 7);
    assign fifo_overrun     = f_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_enb) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_data", {24'd0, wr_data}, {24'd0, mon_e.data});
                chk("wr_grant", {30'd0, grant_id}, mon_e.id);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        sb_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int id, input logic [7:0] d, input logic l);
        req_valid[id]        = 1'b1;
        req_data[id*DW +: DW] = d;
        req_last[id]         = l;
    endtask

    task automatic send_pkt(input int id, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            logic acc;
            int   t;
            drive(id, base + 8'(k), k == n - 1);
            push(id, base + 8'(k));
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = req_valid[id] & req_ready[id];
                cyc();
                t++;
            end
            chk("send_accept", {31'd0, acc}, 1);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        repeat (10) cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 1};
        tbl[1]  = '{4'b1111, 2};
        tbl[2]  = '{4'b1111, 3};
        tbl[3]  = '{4'b1111, 0};
        tbl[4]  = '{4'b1111, 1};
        tbl[5]  = '{4'b0100, 2};
        tbl[6]  = '{4'b0100, 2};
        tbl[7]  = '{4'b1001, 3};
        tbl[8]  = '{4'b1001, 0};
        tbl[9]  = '{4'b0110, 1};
        tbl[10] = '{4'b1000, 3};
        tbl[11] = '{4'b0011, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '1;
        req_last  = '0;
        clear_err = 1'b0;
        rd_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_enb", {31'd0, wr_enb}, 0);
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_err_ovr", {31'd0, err_overrun}, 0);
        chk("rst_err_to", {31'd0, err_timeout}, 0);
        rst_n = 1'b1;

        // 1: three-beat packet from req0 after a one-cycle arbitration bubble
        drive(0, 8'h11, 1'b0);
        @(negedge clk);
        chk("t1_bubble_wr", {31'd0, wr_enb}, 0);
        chk("t1_bubble_busy", {31'd0, busy}, 0);
        cyc();
        push(0, 8'h11);
        @(negedge clk);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_wr0", {31'd0, wr_enb}, 1);
        cyc();
        drive(0, 8'h22, 1'b0);
        push(0, 8'h22);
        @(negedge clk);
        chk("t1_wr1", {31'd0, wr_enb}, 1);
        cyc();
        drive(0, 8'h33, 1'b1);
        push(0, 8'h33);
        @(negedge clk);
        chk("t1_wr2", {31'd0, wr_enb}, 1);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_busy_drop", {31'd0, busy}, 0);
        cyc();

        // 2: single-beat packets, round-robin order from the vector table
        rd_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NR; i++) begin
                req_valid[i]        = tbl[r].mask[i];
                req_data[i*DW +: DW] = 8'(r * 16 + i);
                req_last[i]         = 1'b1;
            end
            @(negedge clk);
            chk("t2_bubble", {31'd0, busy}, 0);
            cyc();
            push(tbl[r].exp_id, 8'(r * 16 + tbl[r].exp_id));
            @(negedge clk);
            chk("t2_grant", {30'd0, grant_id}, tbl[r].exp_id);
            chk("t2_wr", {31'd0, wr_enb}, 1);
            cyc();
            req_valid = '0;
        end
        rd_en = 1'b0;
        drain();

        // 3: ten-beat packet into an 8-deep FIFO with no reads, then two reads
        fork
            send_pkt(1, 10, 8'h60);
            begin
                int t;
                t = 0;
                while (f_cnt != 8 && t < 100) begin
                    cyc();
                    t++;
                end
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_full", {31'd0, fifo_full}, 1);
                    chk("t3_stall_ready", {28'd0, req_ready}, 0);
                end
                cyc();
                rd_en = 1'b1;
                cyc();
                cyc();
                rd_en = 1'b0;
            end
        join
        @(negedge clk);
        chk("t3_overrun", {31'd0, fifo_overrun}, 0);
        chk("t3_err_overrun", {31'd0, err_overrun}, 0);
        chk("t3_busy", {31'd0, busy}, 0);
        cyc();
        drain();

        // 4: owner goes idle for 16 cycles, grant is forced off
        drive(2, 8'h77, 1'b0);
        cyc();
        push(2, 8'h77);
        @(negedge clk);
        cyc();
        req_valid[2] = 1'b0;
        repeat (15) cyc();
        @(negedge clk);
        chk("t4_busy_before", {31'd0, busy}, 1);
        chk("t4_err_before", {31'd0, err_timeout}, 0);
        cyc();
        @(negedge clk);
        chk("t4_busy_after", {31'd0, busy}, 0);
        chk("t4_err_after", {31'd0, err_timeout}, 1);
        cyc();
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", {31'd0, err_timeout}, 0);
        cyc();
        drain();

        // 5: new packet request with FIFO at 7 of 8
        send_pkt(0, 7, 8'hB0);
        @(negedge clk);
        chk("t5_almost_full", {31'd0, fifo_almost_full}, 1);
        cyc();
`ifdef FIFO_ARB_AF_THROTTLE_EN
        drive(3, 8'h90, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_throttled", {31'd0, busy}, 0);
            cyc();
        end
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        @(negedge clk);
        chk("t5_still_idle", {31'd0, busy}, 0);
        cyc();
        push(3, 8'h90);
        @(negedge clk);
        chk("t5_grant", {30'd0, grant_id}, 3);
        chk("t5_wr_a", {31'd0, wr_enb}, 1);
        cyc();
        drive(3, 8'h91, 1'b1);
        push(3, 8'h91);
        @(negedge clk);
        chk("t5_wr_b", {31'd0, wr_enb}, 1);
        cyc();
        req_valid[3] = 1'b0;
`else
        drive(3, 8'h90, 1'b0);
        push(3, 8'h90);
        @(negedge clk);
        chk("t5_bubble", {31'd0, busy}, 0);
        cyc();
        @(negedge clk);
        chk("t5_grant", {30'd0, grant_id}, 3);
        chk("t5_wr_a", {31'd0, wr_enb}, 1);
        cyc();
        drive(3, 8'h91, 1'b1);
        @(negedge clk);
        chk("t5_full_ready", {28'd0, req_ready}, 0);
        chk("t5_full_wr", {31'd0, wr_enb}, 0);
        cyc();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        push(3, 8'h91);
        @(negedge clk);
        chk("t5_wr_b", {31'd0, wr_enb}, 1);
        cyc();
        req_valid[3] = 1'b0;
`endif
        @(negedge clk);
        chk("t5_done", {31'd0, busy}, 0);
        cyc();
        drain();

        // 6: reset in the middle of a four-beat packet
        send_pkt(1, 1, 8'hC8);
        drive(2, 8'hC0, 1'b0);
        cyc();
        push(2, 8'hC0);
        @(negedge clk);
        cyc();
        drive(2, 8'hC1, 1'b0);
        push(2, 8'hC1);
        @(negedge clk);
        cyc();
        drive(2, 8'hC2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", {31'd0, wr_enb}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_grant", {30'd0, grant_id}, 0);
        req_valid = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 8'(8'hD0 + i), 1'b1);
        @(negedge clk);
        chk("t6_bubble", {31'd0, busy}, 0);
        cyc();
        push(0, 8'hD0);
        @(negedge clk);
        chk("t6_first_winner", {30'd0, grant_id}, 0);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
